// File: rtl/merge_nx1.sv
// merge_nx1: N-to-1 write merge, per-channel FIFOs, round-robin drain.
// Optional macro MERGE_CH_TAG_EN adds the o_ch source-channel port.
module merge_nx1 #(
  parameter int NUM_CH     = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        wen,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     ren,
  output logic                     valid,
  output logic [DATA_W-1:0]        o_data,
  output logic                     busy
`ifdef MERGE_CH_TAG_EN
  ,
  output logic [$clog2(NUM_CH)-1:0] o_ch
`endif
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic {
    S_EMPTY,
    S_HOLD
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wp  [NUM_CH];
  logic [AW-1:0]     rp  [NUM_CH];
  logic [NW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] ne;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     gnt;
  logic              hit;
  logic              load;
  logic [CW-1:0]     c;

  // per-channel status and push/pop strobes
  always_comb begin
    ne   = '0;
    full = '0;
    push = '0;
    pop  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ne[k]   = cnt[k] != '0;
      full[k] = cnt[k] == NW'(FIFO_DEPTH);
      push[k] = wen[k] & ~full[k];
      pop[k]  = load & (gnt == CW'(k));
    end
  end

  // circular search for first non-empty channel after ptr
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    c   = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (c == CW'(NUM_CH - 1)) ? '0 : c + CW'(1);
      if (!hit && ne[c]) begin
        hit = 1'b1;
        gnt = c;
      end
    end
  end

  assign valid = (state == S_HOLD);
  assign load  = (!valid || ren) && hit;
  assign busy  = (|ne) | valid;

  // FIFO storage; flushing is done through the pointers
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k])
        mem[k][wp[k]] <= i_data[k*DATA_W +: DATA_W];
    end
  end

  // FIFO pointers, counts and sticky overflow
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wp[k]  <= '0;
        rp[k]  <= '0;
        cnt[k] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k])
          wp[k] <= wp[k] + AW'(1);
        if (pop[k])
          rp[k] <= rp[k] + AW'(1);
        if (push[k] && !pop[k])
          cnt[k] <= cnt[k] + NW'(1);
        else if (pop[k] && !push[k])
          cnt[k] <= cnt[k] - NW'(1);
        if (wen[k] && full[k])
          overflow[k] <= 1'b1;
      end
    end
  end

  // output slot FSM with registered word, tag and RR pointer
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_EMPTY;
      o_data <= '0;
      ptr    <= CW'(NUM_CH - 1);
`ifdef MERGE_CH_TAG_EN
      o_ch   <= '0;
`endif
    end else if (load) begin
      state  <= S_HOLD;
      o_data <= mem[gnt][rp[gnt]];
      ptr    <= gnt;
`ifdef MERGE_CH_TAG_EN
      o_ch   <= gnt;
`endif
    end else if (state == S_HOLD && ren) begin
      state  <= S_EMPTY;
    end
  end

endmodule

// File: tb/tb_merge_nx1.sv
// tb_merge_nx1: directed checks for merge_nx1.
// Build with MERGE_CH_TAG_EN defined to also check o_ch.
module tb_merge_nx1;

  logic        clk_i;
  logic        reset_n;
  logic [8:0]  wen;
  logic [71:0] i_data;
  logic [8:0]  full;
  logic [8:0]  overflow;
  logic        ren;
  logic        valid;
  logic [7:0]  o_data;
  logic        busy;
`ifdef MERGE_CH_TAG_EN
  logic [3:0]  o_ch;
`endif

  int n_err;
  int n_chk;

  merge_nx1 #(
    .NUM_CH(9),
    .DATA_W(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .reset_n(reset_n),
    .wen(wen),
    .i_data(i_data),
    .full(full),
    .overflow(overflow),
    .ren(ren),
    .valid(valid),
    .o_data(o_data),
    .busy(busy)
`ifdef MERGE_CH_TAG_EN
    ,
    .o_ch(o_ch)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_err   = 0;
    n_chk   = 0;
    reset_n = 1'b0;
    wen     = '0;
    i_data  = '0;
    ren     = 1'b0;

    // reset with random stimulus
    for (int i = 0; i < 3; i++) begin
      wen    = 9'($urandom);
      i_data = {8'($urandom), $urandom, $urandom};
      tick();
    end
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_odata", 32'(o_data), 0);
`ifdef MERGE_CH_TAG_EN
    chk("rst_och", 32'(o_ch), 0);
`endif
    wen     = '0;
    i_data  = '0;
    reset_n = 1'b1;
    tick();

    // single word on channel 4
    ren          = 1'b1;
    wen          = 9'h010;
    i_data[32+:8] = 8'hA5;
    tick();
    wen = '0;
    chk("single_busy_t", 32'(busy), 1);
    chk("single_valid_t", 32'(valid), 0);
    tick();
    chk("single_valid", 32'(valid), 1);
    chk("single_data", 32'(o_data), 32'hA5);
`ifdef MERGE_CH_TAG_EN
    chk("single_och", 32'(o_ch), 4);
`endif
    tick();
    chk("single_drop", 32'(valid), 0);
    chk("single_idle", 32'(busy), 0);

    // broadcast from fresh reset
    do_reset();
    ren = 1'b1;
    wen = 9'h1FF;
    for (int k = 0; k < 9; k++)
      i_data[k*8 +: 8] = 8'(k * 17);
    tick();
    wen = '0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("bc_valid", 32'(valid), 1);
      chk("bc_data", 32'(o_data), 32'(k * 17));
`ifdef MERGE_CH_TAG_EN
      chk("bc_och", 32'(o_ch), 32'(k));
`endif
    end
    tick();
    chk("bc_valid_end", 32'(valid), 0);
    chk("bc_busy_end", 32'(busy), 0);

    // backpressure on channel 2
    do_reset();
    ren = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      wen           = 9'h004;
      i_data[16+:8] = 8'(v);
      tick();
    end
    wen = '0;
    chk("bp_valid", 32'(valid), 1);
    chk("bp_slot", 32'(o_data), 1);
    chk("bp_full", 32'(full), 32'h004);
    chk("bp_ovf", 32'(overflow), 32'h004);
    tick();
    chk("bp_hold", 32'(o_data), 1);
    ren = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      chk("bp_valid_drain", 32'(valid), 1);
      chk("bp_order", 32'(o_data), 32'(v));
      tick();
    end
    chk("bp_empty", 32'(valid), 0);
    chk("bp_full_clr", 32'(full), 0);
    chk("bp_ovf_sticky", 32'(overflow), 32'h004);

    // fairness between channels 0 and 1
    do_reset();
    ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        wen          = 9'h003;
        i_data[0+:8] = 8'h10 + 8'(i);
        i_data[8+:8] = 8'h20 + 8'(i);
      end else begin
        wen = '0;
      end
      tick();
      if (i >= 1 && i <= 8) begin
        chk("rr_valid", 32'(valid), 1);
        chk("rr_data", 32'(o_data),
            (((i - 1) % 2) == 1 ? 32'h20 : 32'h10) + 32'((i - 1) / 2));
`ifdef MERGE_CH_TAG_EN
        chk("rr_och", 32'(o_ch), 32'((i - 1) % 2));
`endif
      end
    end
    chk("rr_valid_end", 32'(valid), 0);
    chk("rr_no_ovf", 32'(overflow), 0);

    // mid-operation reset
    do_reset();
    ren = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wen          = 9'h003;
      i_data[0+:8] = 8'h31 + 8'(i);
      i_data[8+:8] = 8'h41 + 8'(i);
      tick();
    end
    wen = '0;
    chk("mr_valid_pre", 32'(valid), 1);
    chk("mr_busy_pre", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_valid_async", 32'(valid), 0);
    chk("mr_busy_async", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    ren     = 1'b1;
    tick();
    tick();
    chk("mr_no_stale", 32'(valid), 0);
    chk("mr_idle", 32'(busy), 0);
    wen           = 9'h080;
    i_data[56+:8] = 8'h77;
    tick();
    wen = '0;
    tick();
    chk("mr_new_valid", 32'(valid), 1);
    chk("mr_new_data", 32'(o_data), 32'h77);
`ifdef MERGE_CH_TAG_EN
    chk("mr_new_och", 32'(o_ch), 7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
